// File: rtl/ddr_bringup_ctrl.sv
// PL DDR (MIG) bring-up sequencer in the clk_200 domain: lock filter, reset hold,
// calibration supervision with bounded retries. All outputs are driven from flops.
module ddr_bringup_ctrl #(
  parameter int LOCK_FILTER   = 16,
  parameter int HOLD_CYCLES   = 9181,
  parameter int HOLD_WIDTH    = 15,
  parameter int CALIB_TIMEOUT = 2000000,
  parameter int TIMEOUT_WIDTH = 21,
  parameter int MAX_RETRIES   = 3,
  parameter int RETRY_WIDTH   = 2
) (
  input  logic                   clk_200,
  input  logic                   sys_rst_i,
  input  logic                   mmcm_locked,
  input  logic                   init_calib_complete,
  input  logic                   restart_i,
  output logic                   mig_sys_rst_n_o,
  output logic                   ddr_ready_o,
  output logic                   calib_fail_o,
  output logic [RETRY_WIDTH-1:0] retry_count_o,
  output logic [2:0]             state_o
);

  localparam int FILTER_WIDTH = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;

  localparam logic [FILTER_WIDTH-1:0]  FILTER_LAST  = FILTER_WIDTH'(LOCK_FILTER - 1);
  localparam logic [HOLD_WIDTH-1:0]    HOLD_LOAD    = HOLD_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(CALIB_TIMEOUT - 1);
  localparam logic [RETRY_WIDTH-1:0]   RETRY_MAX    = RETRY_WIDTH'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_HOLD_RST   = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_RUNNING    = 3'd3,
    ST_FAILED     = 3'd4
  } state_t;

  state_t                   state_r,   state_nx_s;
  logic [FILTER_WIDTH-1:0]  filter_r,  filter_nx_s;
  logic [HOLD_WIDTH-1:0]    hold_r,    hold_nx_s;
  logic [TIMEOUT_WIDTH-1:0] timeout_r, timeout_nx_s;
  logic [RETRY_WIDTH-1:0]   retry_r,   retry_nx_s;
  logic                     rst_n_r;
  logic                     ready_r;
  logic                     fail_r;
  logic                     fail_event_s;
  logic                     lock_loss_s;

  // Next-state and counter logic; lock loss outranks restart, which outranks calibration events.
  always_comb begin
    state_nx_s   = state_r;
    filter_nx_s  = filter_r;
    hold_nx_s    = hold_r;
    timeout_nx_s = timeout_r;
    retry_nx_s   = retry_r;
    fail_event_s = 1'b0;
    lock_loss_s  = !mmcm_locked &&
                   ((state_r == ST_HOLD_RST) || (state_r == ST_WAIT_CALIB) || (state_r == ST_RUNNING));

    if (lock_loss_s) begin
      state_nx_s  = ST_WAIT_LOCK;
      filter_nx_s = {FILTER_WIDTH{1'b0}};
      retry_nx_s  = restart_i ? {RETRY_WIDTH{1'b0}} : retry_r;
    end else if (restart_i) begin
      retry_nx_s  = {RETRY_WIDTH{1'b0}};
      filter_nx_s = {FILTER_WIDTH{1'b0}};
      if (mmcm_locked) begin
        state_nx_s = ST_HOLD_RST;
        hold_nx_s  = HOLD_LOAD;
      end else begin
        state_nx_s = ST_WAIT_LOCK;
      end
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (!mmcm_locked) begin
            filter_nx_s = {FILTER_WIDTH{1'b0}};
          end else if (filter_r == FILTER_LAST) begin
            state_nx_s  = ST_HOLD_RST;
            hold_nx_s   = HOLD_LOAD;
            filter_nx_s = {FILTER_WIDTH{1'b0}};
          end else begin
            filter_nx_s = filter_r + FILTER_WIDTH'(1);
          end
        end
        ST_HOLD_RST: begin
          if (hold_r == {HOLD_WIDTH{1'b0}}) begin
            state_nx_s   = ST_WAIT_CALIB;
            timeout_nx_s = {TIMEOUT_WIDTH{1'b0}};
          end else begin
            hold_nx_s = hold_r - HOLD_WIDTH'(1);
          end
        end
        ST_WAIT_CALIB: begin
          // Calibration arriving on the timeout cycle still counts as success.
          if (init_calib_complete) begin
            state_nx_s = ST_RUNNING;
          end else if (timeout_r == TIMEOUT_LAST) begin
            fail_event_s = 1'b1;
          end else begin
            timeout_nx_s = timeout_r + TIMEOUT_WIDTH'(1);
          end
        end
        ST_RUNNING: begin
          if (!init_calib_complete) begin
            fail_event_s = 1'b1;
          end else begin
            state_nx_s = ST_RUNNING;
          end
        end
        ST_FAILED: begin
          state_nx_s = ST_FAILED;
        end
        default: begin
          state_nx_s  = ST_WAIT_LOCK;
          filter_nx_s = {FILTER_WIDTH{1'b0}};
        end
      endcase

      if (fail_event_s) begin
        if (retry_r < RETRY_MAX) begin
          retry_nx_s = retry_r + RETRY_WIDTH'(1);
          state_nx_s = ST_HOLD_RST;
          hold_nx_s  = HOLD_LOAD;
        end else begin
          state_nx_s = ST_FAILED;
        end
      end else begin
        retry_nx_s = retry_nx_s;
      end
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so they change with it.
  always_ff @(posedge clk_200) begin
    if (sys_rst_i) begin
      state_r   <= ST_WAIT_LOCK;
      filter_r  <= {FILTER_WIDTH{1'b0}};
      hold_r    <= {HOLD_WIDTH{1'b0}};
      timeout_r <= {TIMEOUT_WIDTH{1'b0}};
      retry_r   <= {RETRY_WIDTH{1'b0}};
      rst_n_r   <= 1'b0;
      ready_r   <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      filter_r  <= filter_nx_s;
      hold_r    <= hold_nx_s;
      timeout_r <= timeout_nx_s;
      retry_r   <= retry_nx_s;
      rst_n_r   <= (state_nx_s == ST_WAIT_CALIB) || (state_nx_s == ST_RUNNING);
      ready_r   <= (state_nx_s == ST_RUNNING);
      fail_r    <= (state_nx_s == ST_FAILED);
    end
  end

  assign mig_sys_rst_n_o = rst_n_r;
  assign ddr_ready_o     = ready_r;
  assign calib_fail_o    = fail_r;
  assign retry_count_o   = retry_r;
  assign state_o         = state_r;

endmodule

// File: tb/tb_ddr_bringup_ctrl.sv
// Directed bench for ddr_bringup_ctrl with small parameters (filter 4, hold 8, timeout 32, 2 retries).
module tb_ddr_bringup_ctrl;

  localparam int RW = 2;

  logic          clk_200 = 1'b0;
  logic          sys_rst_i;
  logic          mmcm_locked;
  logic          init_calib_complete;
  logic          restart_i;
  logic          mig_sys_rst_n_o;
  logic          ddr_ready_o;
  logic          calib_fail_o;
  logic [RW-1:0] retry_count_o;
  logic [2:0]    state_o;

  int total = 0;
  int bad   = 0;
  int n;
  int rst_bad;
  int glitch_seq [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

  ddr_bringup_ctrl #(
    .LOCK_FILTER  (4),
    .HOLD_CYCLES  (8),
    .HOLD_WIDTH   (4),
    .CALIB_TIMEOUT(32),
    .TIMEOUT_WIDTH(5),
    .MAX_RETRIES  (2),
    .RETRY_WIDTH  (RW)
  ) dut (
    .clk_200            (clk_200),
    .sys_rst_i          (sys_rst_i),
    .mmcm_locked        (mmcm_locked),
    .init_calib_complete(init_calib_complete),
    .restart_i          (restart_i),
    .mig_sys_rst_n_o    (mig_sys_rst_n_o),
    .ddr_ready_o        (ddr_ready_o),
    .calib_fail_o       (calib_fail_o),
    .retry_count_o      (retry_count_o),
    .state_o            (state_o)
  );

  always #5 clk_200 = ~clk_200;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_200);
    #1;
  endtask

  // Counts consecutive samples spent in state st (bounded) and samples where rst_n differs from rst_exp.
  task automatic dwell(input logic [2:0] st, input logic rst_exp, output int cnt, output int rbad);
    cnt  = 0;
    rbad = 0;
    while (state_o === st && cnt < 200) begin
      cnt++;
      if (mig_sys_rst_n_o !== rst_exp) rbad++;
      step();
    end
  endtask

  initial begin
    sys_rst_i = 1'b1; mmcm_locked = 1'b0; init_calib_complete = 1'b0; restart_i = 1'b0;

    // Nominal bring-up
    step(); step();
    chk("rst_state", state_o, 3'd0);
    chk("rst_rstn", mig_sys_rst_n_o, 1'b0);
    chk("rst_ready", ddr_ready_o, 1'b0);
    chk("rst_fail", calib_fail_o, 1'b0);
    chk("rst_retry", retry_count_o, 2'd0);
    sys_rst_i = 1'b0; mmcm_locked = 1'b1;
    step(); step(); step();
    chk("nom_filter_wait", state_o, 3'd0);
    step();
    chk("nom_hold_entry", state_o, 3'd1);
    dwell(3'd1, 1'b0, n, rst_bad);
    chk("nom_hold_len", n, 8);
    chk("nom_hold_rstn_low", rst_bad, 0);
    chk("nom_calib_entry", state_o, 3'd2);
    chk("nom_release", mig_sys_rst_n_o, 1'b1);
    for (int i = 0; i < 19; i++) step();
    chk("nom_still_wait", state_o, 3'd2);
    init_calib_complete = 1'b1;
    step();
    chk("nom_running", state_o, 3'd3);
    chk("nom_ready", ddr_ready_o, 1'b1);
    chk("nom_retry", retry_count_o, 2'd0);

    // Lock glitch restarts the filter
    sys_rst_i = 1'b1; mmcm_locked = 1'b0; init_calib_complete = 1'b0;
    step();
    chk("rst2_state", state_o, 3'd0);
    chk("rst2_ready", ddr_ready_o, 1'b0);
    sys_rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mmcm_locked = glitch_seq[i][0];
      step();
      chk($sformatf("glitch_%0d", i), state_o, (i == 7) ? 3'd1 : 3'd0);
    end

    // Timeout, retries, then FAILED
    for (int a = 0; a < 3; a++) begin
      chk($sformatf("att%0d_retry", a), retry_count_o, a);
      dwell(3'd1, 1'b0, n, rst_bad);
      chk($sformatf("att%0d_hold_len", a), n, 8);
      chk($sformatf("att%0d_hold_rstn", a), rst_bad, 0);
      dwell(3'd2, 1'b1, n, rst_bad);
      chk($sformatf("att%0d_wait_len", a), n, 32);
      chk($sformatf("att%0d_wait_rstn", a), rst_bad, 0);
    end
    chk("fail_state", state_o, 3'd4);
    chk("fail_flag", calib_fail_o, 1'b1);
    chk("fail_rstn", mig_sys_rst_n_o, 1'b0);
    chk("fail_ready", ddr_ready_o, 1'b0);
    chk("fail_retry", retry_count_o, 2'd2);
    mmcm_locked = 1'b0;
    step(); step();
    chk("fail_lockloss_stays", state_o, 3'd4);
    mmcm_locked = 1'b1; restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    chk("restart_state", state_o, 3'd1);
    chk("restart_retry", retry_count_o, 2'd0);
    chk("restart_fail", calib_fail_o, 1'b0);

    // Calibration on the timeout cycle wins, then calibration drop
    dwell(3'd1, 1'b0, n, rst_bad);
    chk("bnd_hold_len", n, 8);
    for (int i = 0; i < 31; i++) step();
    chk("bnd_last_wait", state_o, 3'd2);
    init_calib_complete = 1'b1;
    step();
    chk("bnd_running", state_o, 3'd3);
    chk("bnd_ready", ddr_ready_o, 1'b1);
    chk("bnd_retry", retry_count_o, 2'd0);
    init_calib_complete = 1'b0;
    step();
    chk("drop_state", state_o, 3'd1);
    chk("drop_ready", ddr_ready_o, 1'b0);
    chk("drop_rstn", mig_sys_rst_n_o, 1'b0);
    chk("drop_retry", retry_count_o, 2'd1);

    // Lock loss at hold counter 3
    step(); step(); step(); step();
    chk("ll_mid_hold", state_o, 3'd1);
    mmcm_locked = 1'b0;
    step();
    chk("ll_state", state_o, 3'd0);
    chk("ll_retry", retry_count_o, 2'd1);
    chk("ll_rstn", mig_sys_rst_n_o, 1'b0);
    mmcm_locked = 1'b1;
    step(); step(); step();
    chk("ll_filter_wait", state_o, 3'd0);
    step();
    chk("ll_rehold", state_o, 3'd1);
    dwell(3'd1, 1'b0, n, rst_bad);
    chk("ll_hold_len", n, 8);
    chk("ll_hold_rstn", rst_bad, 0);
    init_calib_complete = 1'b1;
    step();
    chk("ll_running", state_o, 3'd3);
    chk("ll_retry_kept", retry_count_o, 2'd1);

    // Reset beats restart and lock loss
    sys_rst_i = 1'b1; restart_i = 1'b1; mmcm_locked = 1'b0;
    step();
    chk("fin_state", state_o, 3'd0);
    chk("fin_rstn", mig_sys_rst_n_o, 1'b0);
    chk("fin_ready", ddr_ready_o, 1'b0);
    chk("fin_fail", calib_fail_o, 1'b0);
    chk("fin_retry", retry_count_o, 2'd0);
    sys_rst_i = 1'b0; restart_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
